pipe_hazard_ctrl: RTL and testbench

- Central stall/flush/forward controller for the 5-stage pipeline.
- Drives the enable and flush inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers and the PC.
- Detects load-use and taken-branch hazards and selects EX operand forwarding.
- Sequences whole-pipeline freezes while a data-memory access waits for its acknowledge, with a bounded-wait watchdog.

---
 rtl/pipe_pkg.sv | 23 ++
 rtl/pipe_fwd_unit.sv | 42 ++++
 rtl/pipe_hazard_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// ---------------------------------------------------------------------------
// pipe_pkg
// Shared types and constants for the 5-stage pipeline hazard controller.
//   fwd_sel_e  : EX operand forwarding select (regfile / MEM / WB)
//   hz_state_e : hazard controller FSM state (RUN / MEM_WAIT)
//   REG_ZERO   : architectural zero register index (never forwarded)
// ---------------------------------------------------------------------------
package pipe_pkg;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_MEM = 2'b01,
    FWD_WB  = 2'b10
  } fwd_sel_e;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } hz_state_e;

  localparam int unsigned REG_ZERO = 0;

endpackage

// File: rtl/pipe_fwd_unit.sv
// ---------------------------------------------------------------------------
// pipe_fwd_unit
// Purely combinational forwarding select for one EX operand.
// Ports:
//   rs_addr_i   in  source register of the operand in execute
//   rd_addr_m_i in  memory-stage destination register
//   rd_wr_m_i   in  memory-stage writes rd
//   rd_addr_w_i in  writeback-stage destination register
//   rd_wr_w_i   in  writeback-stage writes rd
//   fwd_sel_o   out 00 = regfile, 01 = MEM result, 10 = WB data
// ---------------------------------------------------------------------------
module pipe_fwd_unit
  import pipe_pkg::*;
#(
  parameter int XLEN_ADDR = 5
) (
  input  logic [XLEN_ADDR-1:0] rs_addr_i,
  input  logic [XLEN_ADDR-1:0] rd_addr_m_i,
  input  logic                 rd_wr_m_i,
  input  logic [XLEN_ADDR-1:0] rd_addr_w_i,
  input  logic                 rd_wr_w_i,
  output logic [1:0]           fwd_sel_o
);

  localparam logic [XLEN_ADDR-1:0] ZERO_ADDR = XLEN_ADDR'(REG_ZERO);

  fwd_sel_e sel;

  // MEM is younger than WB, so its result wins when both match.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    sel = FWD_RF;
    if (rd_wr_m_i && (rd_addr_m_i != ZERO_ADDR) && (rd_addr_m_i == rs_addr_i)) begin
      sel = FWD_MEM;
    end else if (rd_wr_w_i && (rd_addr_w_i != ZERO_ADDR) && (rd_addr_w_i == rs_addr_i)) begin
      sel = FWD_WB;
    end
  end

  assign fwd_sel_o = sel;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl
// Central stall / flush / forward controller for the 5-stage pipeline.
// Optional build macro: PIPE_HAZARD_PERF_EN adds 32-bit performance counters.
// Ports:
//   clk, rst                         clock (rising edge), async active-high reset
//   rs1_addr_d, rs2_addr_d           decode-stage sources (load-use detection)
//   rs1_addr_e, rs2_addr_e           execute-stage sources (forwarding)
//   rd_addr_e, rd_wr_e, wb_sel_e     execute destination, write flag, is-load
//   rd_addr_m, rd_wr_m               memory-stage destination and write flag
//   rd_addr_w, rd_wr_w               writeback-stage destination and write flag
//   br_taken_e                       branch/jump resolved taken in execute
//   mem_req_m, mem_ack_m             data-memory request / acknowledge
//   en_pc, en_fd, en_de, en_em, en_mw  register enables
//   flush_fd, flush_de               bubble insert for IF/ID and ID/EX
//   fwd_a_e, fwd_b_e                 operand forwarding selects
//   mem_err                          sticky memory watchdog error
//   stall_mem_cnt, stall_lu_cnt, flush_cnt  (PIPE_HAZARD_PERF_EN only)
// ---------------------------------------------------------------------------
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int XLEN_ADDR   = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [XLEN_ADDR-1:0] rs1_addr_d,
  input  logic [XLEN_ADDR-1:0] rs2_addr_d,
  input  logic [XLEN_ADDR-1:0] rs1_addr_e,
  input  logic [XLEN_ADDR-1:0] rs2_addr_e,
  input  logic [XLEN_ADDR-1:0] rd_addr_e,
  input  logic                 rd_wr_e,
  input  logic                 wb_sel_e,
  input  logic [XLEN_ADDR-1:0] rd_addr_m,
  input  logic                 rd_wr_m,
  input  logic [XLEN_ADDR-1:0] rd_addr_w,
  input  logic                 rd_wr_w,
  input  logic                 br_taken_e,
  input  logic                 mem_req_m,
  input  logic                 mem_ack_m,
  output logic                 en_pc,
  output logic                 en_fd,
  output logic                 en_de,
  output logic                 en_em,
  output logic                 en_mw,
  output logic                 flush_fd,
  output logic                 flush_de,
  output logic [1:0]           fwd_a_e,
  output logic [1:0]           fwd_b_e,
  output logic                 mem_err
`ifdef PIPE_HAZARD_PERF_EN
  ,
  output logic [31:0]          stall_mem_cnt,
  output logic [31:0]          stall_lu_cnt,
  output logic [31:0]          flush_cnt
`endif
);

  localparam int                   CNT_W     = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0]     CNT_MAX   = CNT_W'(MEM_TIMEOUT);
  localparam logic [XLEN_ADDR-1:0] ZERO_ADDR = XLEN_ADDR'(REG_ZERO);

  hz_state_e        state_q, state_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0] wait_inc;
  logic             mem_err_q, mem_err_d;
  logic             lu_hazard;
  logic [1:0]       fwd_a_raw, fwd_b_raw;

  assign lu_hazard = rd_wr_e && wb_sel_e && (rd_addr_e != ZERO_ADDR) &&
                     ((rd_addr_e == rs1_addr_d) || (rd_addr_e == rs2_addr_d));

  // Saturating watchdog increment; the count clears on the ack, so only
  // cycles still waiting for data move it towards the timeout.
  assign wait_inc = (wait_cnt_q == CNT_MAX) ? wait_cnt_q : wait_cnt_q + 1'b1;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= RUN;
      wait_cnt_q <= '0;
      mem_err_q  <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      mem_err_q  <= mem_err_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    mem_err_d  = mem_err_q;
    unique case (state_q)
      RUN: begin
        // A same-cycle ack completes without ever entering the wait state.
        if (mem_req_m && !mem_ack_m) state_d = MEM_WAIT;
      end
      MEM_WAIT: begin
        if (mem_ack_m) begin
          state_d    = RUN;
          wait_cnt_d = '0;
        end else begin
          wait_cnt_d = wait_inc;
          if (wait_inc == CNT_MAX) mem_err_d = 1'b1;
        end
      end
      default: state_d = RUN;
    endcase
  end

  // Output logic: reset > memory freeze > taken branch > load-use > run.
  always_comb begin
    en_pc    = 1'b1;
    en_fd    = 1'b1;
    en_de    = 1'b1;
    en_em    = 1'b1;
    en_mw    = 1'b1;
    flush_fd = 1'b0;
    flush_de = 1'b0;
    if (rst) begin
      {en_pc, en_fd, en_de, en_em, en_mw} = '0;
      flush_fd = 1'b1;
      flush_de = 1'b1;
    end else if (state_q == MEM_WAIT) begin
      // The ack cycle is still frozen; the pipeline advances on the next one.
      {en_pc, en_fd, en_de, en_em, en_mw} = '0;
    end else if (br_taken_e) begin
      // The dependent instruction, if any, is squashed, so no stall is needed.
      flush_fd = 1'b1;
      flush_de = 1'b1;
    end else if (lu_hazard) begin
      // Hold PC and IF/ID and load a bubble into ID/EX; one cycle later
      // the load sits in MEM and the forwarding path covers the use.
      en_pc    = 1'b0;
      en_fd    = 1'b0;
      flush_de = 1'b1;
    end
  end

  pipe_fwd_unit #(.XLEN_ADDR(XLEN_ADDR)) u_fwd_a (
    .rs_addr_i   (rs1_addr_e),
    .rd_addr_m_i (rd_addr_m),
    .rd_wr_m_i   (rd_wr_m),
    .rd_addr_w_i (rd_addr_w),
    .rd_wr_w_i   (rd_wr_w),
    .fwd_sel_o   (fwd_a_raw)
  );

  pipe_fwd_unit #(.XLEN_ADDR(XLEN_ADDR)) u_fwd_b (
    .rs_addr_i   (rs2_addr_e),
    .rd_addr_m_i (rd_addr_m),
    .rd_wr_m_i   (rd_wr_m),
    .rd_addr_w_i (rd_addr_w),
    .rd_wr_w_i   (rd_wr_w),
    .fwd_sel_o   (fwd_b_raw)
  );

  assign fwd_a_e = rst ? FWD_RF : fwd_a_raw;
  assign fwd_b_e = rst ? FWD_RF : fwd_b_raw;
  assign mem_err = mem_err_q;

`ifdef PIPE_HAZARD_PERF_EN
  logic [31:0] stall_mem_cnt_q, stall_lu_cnt_q, flush_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_mem_cnt_q <= '0;
      stall_lu_cnt_q  <= '0;
      flush_cnt_q     <= '0;
    end else begin
      if (state_q == MEM_WAIT) stall_mem_cnt_q <= stall_mem_cnt_q + 32'd1;
      if (state_q == RUN && !br_taken_e && lu_hazard) stall_lu_cnt_q <= stall_lu_cnt_q + 32'd1;
      if (state_q == RUN && br_taken_e) flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign stall_mem_cnt = stall_mem_cnt_q;
  assign stall_lu_cnt  = stall_lu_cnt_q;
  assign flush_cnt     = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
// Self-checking bench for pipe_hazard_ctrl (MEM_TIMEOUT = 4). Directed
// scenarios followed by randomized traffic, all compared against a
// behavioural model of the hazard rules.
// ---------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

  localparam int TO = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] rs1_addr_d, rs2_addr_d, rs1_addr_e, rs2_addr_e;
  logic [4:0] rd_addr_e, rd_addr_m, rd_addr_w;
  logic       rd_wr_e, wb_sel_e, rd_wr_m, rd_wr_w;
  logic       br_taken_e, mem_req_m, mem_ack_m;
  logic       en_pc, en_fd, en_de, en_em, en_mw;
  logic       flush_fd, flush_de;
  logic [1:0] fwd_a_e, fwd_b_e;
  logic       mem_err;

  int checks   = 0;
  int failures = 0;

  // Behavioural model: whether the pipeline is waiting on memory, how many
  // un-acked wait cycles have elapsed, and the sticky error.
  bit m_wait;
  int m_cycles;
  bit m_err;

  pipe_hazard_ctrl #(.MEM_TIMEOUT(TO), .XLEN_ADDR(5)) dut (
    .clk        (clk),
    .rst        (rst),
    .rs1_addr_d (rs1_addr_d),
    .rs2_addr_d (rs2_addr_d),
    .rs1_addr_e (rs1_addr_e),
    .rs2_addr_e (rs2_addr_e),
    .rd_addr_e  (rd_addr_e),
    .rd_wr_e    (rd_wr_e),
    .wb_sel_e   (wb_sel_e),
    .rd_addr_m  (rd_addr_m),
    .rd_wr_m    (rd_wr_m),
    .rd_addr_w  (rd_addr_w),
    .rd_wr_w    (rd_wr_w),
    .br_taken_e (br_taken_e),
    .mem_req_m  (mem_req_m),
    .mem_ack_m  (mem_ack_m),
    .en_pc      (en_pc),
    .en_fd      (en_fd),
    .en_de      (en_de),
    .en_em      (en_em),
    .en_mw      (en_mw),
    .flush_fd   (flush_fd),
    .flush_de   (flush_de),
    .fwd_a_e    (fwd_a_e),
    .fwd_b_e    (fwd_b_e),
    .mem_err    (mem_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [4:0] en_vec();
    return {en_pc, en_fd, en_de, en_em, en_mw};
  endfunction

  // Forwarding reference: the youngest matching non-zero producer wins.
  function automatic logic [1:0] ref_fwd(input logic [4:0] rs);
    logic [1:0] sel = 2'b00;
    if (rst) return 2'b00;
    if (rd_wr_w && rd_addr_w != 0 && rd_addr_w == rs) sel = 2'b10;
    if (rd_wr_m && rd_addr_m != 0 && rd_addr_m == rs) sel = 2'b01;
    return sel;
  endfunction

  task automatic check_all(input string tag);
    logic [4:0] exp_en;
    logic [1:0] exp_fl;
    bit         lu;
    lu = rd_wr_e && wb_sel_e && rd_addr_e != 0 &&
         (rd_addr_e == rs1_addr_d || rd_addr_e == rs2_addr_d);
    if (rst)             begin exp_en = 5'b00000; exp_fl = 2'b11; end
    else if (m_wait)     begin exp_en = 5'b00000; exp_fl = 2'b00; end
    else if (br_taken_e) begin exp_en = 5'b11111; exp_fl = 2'b11; end
    else if (lu)         begin exp_en = 5'b00111; exp_fl = 2'b01; end
    else                 begin exp_en = 5'b11111; exp_fl = 2'b00; end
    chk({tag, ".en"},    32'(en_vec()), 32'(exp_en));
    chk({tag, ".flush"}, 32'({flush_fd, flush_de}), 32'(exp_fl));
    chk({tag, ".fwd_a"}, 32'(fwd_a_e), 32'(ref_fwd(rs1_addr_e)));
    chk({tag, ".fwd_b"}, 32'(fwd_b_e), 32'(ref_fwd(rs2_addr_e)));
    chk({tag, ".err"},   32'(mem_err), 32'(m_err));
  endtask

  task automatic model_reset();
    m_wait   = 1'b0;
    m_cycles = 0;
    m_err    = 1'b0;
  endtask

  // Advance the model with the inputs that were present at the clock edge.
  task automatic model_edge();
    if (rst) begin
      model_reset();
    end else if (m_wait) begin
      if (mem_ack_m) begin
        m_wait   = 1'b0;
        m_cycles = 0;
      end else begin
        m_cycles++;
        if (m_cycles >= TO) m_err = 1'b1;
      end
    end else if (mem_req_m && !mem_ack_m) begin
      m_wait = 1'b1;
    end
  endtask

  // One cycle: settle, compare against the model, clock, update model.
  task automatic cyc(input string tag);
    #1;
    check_all(tag);
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle_inputs();
    rs1_addr_d = '0; rs2_addr_d = '0; rs1_addr_e = '0; rs2_addr_e = '0;
    rd_addr_e  = '0; rd_addr_m  = '0; rd_addr_w  = '0;
    rd_wr_e = 1'b0; wb_sel_e = 1'b0; rd_wr_m = 1'b0; rd_wr_w = 1'b0;
    br_taken_e = 1'b0; mem_req_m = 1'b0; mem_ack_m = 1'b0;
  endtask

  task automatic assert_rst();
    rst = 1'b1;
    model_reset();
  endtask

  initial begin
    idle_inputs();
    assert_rst();

    // Reset state
    #2;
    chk("rst.en", 32'(en_vec()), 32'h0);
    chk("rst.flush", 32'({flush_fd, flush_de}), 32'h3);
    chk("rst.err", 32'(mem_err), 32'h0);
    cyc("rst");
    cyc("rst");
    rst = 1'b0;
    cyc("idle");

    // Load-use: exactly one bubble
    rd_wr_e = 1'b1; wb_sel_e = 1'b1; rd_addr_e = 5'd5; rs1_addr_d = 5'd5;
    #1;
    chk("lu.en", 32'(en_vec()), 32'h07);
    chk("lu.flush", 32'({flush_fd, flush_de}), 32'h1);
    cyc("lu");
    idle_inputs();
    rd_wr_m = 1'b1; rd_addr_m = 5'd5; rs1_addr_e = 5'd5;
    #1;
    chk("lu_next.en", 32'(en_vec()), 32'h1f);
    chk("lu_next.fwd_a", 32'(fwd_a_e), 32'h1);
    cyc("lu_next");

    // Taken branch overrides load-use
    idle_inputs();
    rd_wr_e = 1'b1; wb_sel_e = 1'b1; rd_addr_e = 5'd5; rs2_addr_d = 5'd5; br_taken_e = 1'b1;
    #1;
    chk("br.en", 32'(en_vec()), 32'h1f);
    chk("br.flush", 32'({flush_fd, flush_de}), 32'h3);
    cyc("br");

    // Memory wait: three un-acked cycles plus the ack cycle are frozen
    idle_inputs();
    mem_req_m = 1'b1;
    #1;
    chk("mreq.en", 32'(en_vec()), 32'h1f);
    cyc("mreq");
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("mwait.en", 32'(en_vec()), 32'h0);
      cyc("mwait");
    end
    mem_ack_m = 1'b1;
    #1;
    chk("mack.en", 32'(en_vec()), 32'h0);
    chk("mack.flush", 32'({flush_fd, flush_de}), 32'h0);
    cyc("mack");
    idle_inputs();
    #1;
    chk("mdone.en", 32'(en_vec()), 32'h1f);
    chk("mdone.err", 32'(mem_err), 32'h0);
    cyc("mdone");

    // Watchdog: error after TO un-acked wait cycles, sticky through the ack
    mem_req_m = 1'b1;
    cyc("to_req");
    for (int i = 1; i <= 6; i++) begin
      cyc("to_wait");
      #1;
      chk("to.err", 32'(mem_err), (i >= TO) ? 32'h1 : 32'h0);
    end
    mem_ack_m = 1'b1;
    cyc("to_ack");
    idle_inputs();
    #1;
    chk("to_after.err", 32'(mem_err), 32'h1);
    chk("to_after.en", 32'(en_vec()), 32'h1f);
    cyc("to_after");

    // Forwarding priority and x0
    rd_addr_m = 5'd7; rd_addr_w = 5'd7; rd_wr_m = 1'b1; rd_wr_w = 1'b1; rs1_addr_e = 5'd7;
    #1;
    chk("fwd.mem", 32'(fwd_a_e), 32'h1);
    cyc("fwd_mem");
    rd_wr_m = 1'b0;
    #1;
    chk("fwd.wb", 32'(fwd_a_e), 32'h2);
    cyc("fwd_wb");
    rd_wr_m = 1'b1; rd_addr_m = 5'd0; rd_addr_w = 5'd0; rs1_addr_e = 5'd0;
    #1;
    chk("fwd.x0", 32'(fwd_a_e), 32'h0);
    cyc("fwd_x0");

    // Reset during MEM_WAIT with a pending ack
    idle_inputs();
    mem_req_m = 1'b1;
    cyc("rw_req");
    cyc("rw_wait");
    mem_ack_m = 1'b1;
    assert_rst();
    #1;
    chk("rw_rst.flush", 32'({flush_fd, flush_de}), 32'h3);
    chk("rw_rst.en", 32'(en_vec()), 32'h0);
    chk("rw_rst.err", 32'(mem_err), 32'h0);
    cyc("rw_rst");
    idle_inputs();
    rst = 1'b0;
    #1;
    chk("rw_rel.en", 32'(en_vec()), 32'h1f);
    cyc("rw_rel");

    // Randomized traffic against the model
    for (int n = 0; n < 500; n++) begin
      rs1_addr_d = 5'($urandom_range(0, 3));
      rs2_addr_d = 5'($urandom_range(0, 3));
      rs1_addr_e = 5'($urandom_range(0, 3));
      rs2_addr_e = 5'($urandom_range(0, 3));
      rd_addr_e  = 5'($urandom_range(0, 3));
      rd_addr_m  = 5'($urandom_range(0, 3));
      rd_addr_w  = 5'($urandom_range(0, 3));
      rd_wr_e    = 1'($urandom_range(0, 1));
      wb_sel_e   = 1'($urandom_range(0, 1));
      rd_wr_m    = 1'($urandom_range(0, 1));
      rd_wr_w    = 1'($urandom_range(0, 1));
      br_taken_e = ($urandom_range(0, 4) == 0);
      mem_req_m  = ($urandom_range(0, 3) == 0);
      mem_ack_m  = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 99) == 0) assert_rst();
      else rst = 1'b0;
      cyc("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
